serv_predecode_fifo: RTL and testbench
======================================

// Module: serv_predecode_fifo
// PURPOSE
//  Parametrised instruction queue between the ibus and serv_decode. Buffers DEPTH fetched words.
//  Predecodes the per-word control flags (ebreak, jal/jalr, mret, wfi, mdu) so the control
//  path reads them without waiting on the full decoder. Presents the head entry with a valid/consume handshake.
// PARAMETERS
//  DEPTH         2  entries; power of two, >=2
//  PRE_REGISTER  1  1: flags decoded at write, stored per entry; 0: flags decoded combinationally from head word
//  MDU           0  1: enable o_mdu_op decode; 0: o_mdu_op tied 0
// PORTS
//  clk            in   1               clock, rising edge
//  i_rst          in   1               reset, asynchronous, active-high
//  i_wb_rdt       in   30              fetched instruction bits [31:2]
//  i_wb_en        in   1               write strobe, one word per cycle
//  i_flush        in   1               discard all entries (redirect/trap)
//  i_rd_en        in   1               consume head entry
//  o_full         out  1               count==DEPTH
//  o_valid        out  1               count!=0
//  o_count        out  $clog2(DEPTH)+1 occupancy
//  o_ovf          out  1               sticky: write attempted while full
//  o_rdt          out  30              head word; 0 when !o_valid
//  o_ebreak       out  1               head is EBREAK
//  o_jal_or_jalr  out  1               head is JAL or JALR
//  o_mret         out  1               head is MRET
//  o_wfi          out  1               head is WFI
//  o_mdu_op       out  1               head is an M-extension op
// BEHAVIOUR
//  - Reset (async, i_rst=1): wr_ptr=rd_ptr=0, count=0, o_ovf=0. All outputs 0. Storage is not reset.
//  - Flags are decoded from the word bits: op=w[6:2], f3=w[14:12], imm=w[31:20].
//    jal_or_jalr = op==11011 | op==11001.
//    For op==11100, f3==000, rs1=rd=0: ebreak imm==0x001, mret imm==0x302, wfi imm==0x105.
//    mdu = MDU & op==01100 & w[31:25]==0000001.
//  - All flags and o_rdt are ANDed with o_valid.
//  - Write: accepted when i_wb_en & !o_full. The word is stored at wr_ptr; wr_ptr advances mod DEPTH.
//    Write while full: word dropped, o_ovf set. o_ovf clears only on reset or flush.
//  - Read: accepted when i_rd_en & o_valid. rd_ptr advances mod DEPTH. i_rd_en while empty is ignored.
//  - Simultaneous accepted read+write: count unchanged, both pointers advance.
//    When full, the write is still dropped even if a read occurs in the same cycle (no pass-through).
//  - Latency: a word written at edge t is visible at the head after edge t. No bypass from
//    i_wb_rdt to o_rdt while empty. o_full/o_count update the same edge.
//  - Flush: on the next edge, pointers, count and o_ovf go to 0.
//    Flush wins over a write or read in the same cycle; that write is lost.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally. count distinguishes full from empty.
//  - PRE_REGISTER=1: the 5 flags are stored beside each word. Outputs are identical to PRE_REGISTER=0.
// STRUCTURE
//  - serv_predecode_defs.vh holds the shared opcode/funct/imm localparams (OP_JAL, OP_JALR,
//    OP_SYSTEM, OP_OP, IMM_EBREAK, IMM_MRET, IMM_WFI, F7_MULDIV) for reuse by serv_decode.
//  - Sub-module serv_predecode_flags: purely combinational, 30b word -> 5 flags, MDU parameter.
//    Instantiated at the write port (PRE_REGISTER=1) or at the head (PRE_REGISTER=0).
//  - Top level holds the storage array, pointers, counter and ovf flag.
// TESTING
//  Run every test for DEPTH in {2,4} x PRE_REGISTER in {0,1}; MDU=1 except where noted.
//  1 Write 0x0004001C (ebreak), 0x0C08001C (mret), 0x0414001C (wfi), 0x0000001B (jal), one per cycle at DEPTH=4,
//    then read four times -> each flag asserts alone on its own entry; count steps 4,3,2,1,0.
//  2 Write 0x008C402C (mul) -> o_mdu_op=1. Repeat with MDU=0 -> o_mdu_op=0, o_valid=1.
//  3 DEPTH=2: three writes back-to-back -> o_full after the 2nd; 3rd dropped; o_ovf=1; reads return words 1,2 only.
//  4 Hold i_wb_en and i_rd_en together for 10 cycles starting at count=1 -> count stays 1;
//    words emerge in FIFO order across pointer wrap.
//  5 Assert i_flush with i_wb_en=1 at count=2 -> next cycle count=0, o_valid=0, o_ovf=0, all flags 0.
//  6 Assert i_rst asynchronously mid-stream between edges -> outputs 0 immediately;
//    the first write after release lands at entry 0.

Source files
------------

// File: rtl/serv_predecode_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serv_predecode_fifo_pkg
//  Description : Shared opcode / funct / immediate encodings used to
//                predecode control-flow and system instructions, plus the
//                packed flag bundle carried beside each queued word.
//                Also intended for reuse by serv_decode so the encodings
//                live in exactly one place.
//  Revision    : 1.0 - initial release
// ============================================================================
package serv_predecode_fifo_pkg;

    // Major opcodes, instruction bits [6:2]
    localparam logic [4:0]  OP_JAL     = 5'b11011;
    localparam logic [4:0]  OP_JALR    = 5'b11001;
    localparam logic [4:0]  OP_SYSTEM  = 5'b11100;
    localparam logic [4:0]  OP_OP      = 5'b01100;

    // SYSTEM-opcode immediates, instruction bits [31:20]
    localparam logic [11:0] IMM_EBREAK = 12'h001;
    localparam logic [11:0] IMM_MRET   = 12'h302;
    localparam logic [11:0] IMM_WFI    = 12'h105;

    // funct7 selecting the M extension within OP, instruction bits [31:25]
    localparam logic [6:0]  F7_MULDIV  = 7'b0000001;

    // Width of the fetched word: instruction bits [31:2]
    localparam int          WORD_W     = 30;

    // Predecoded control flags for one instruction word
    typedef struct packed {
        logic ebreak;
        logic jal_or_jalr;
        logic mret;
        logic wfi;
        logic mdu;
    } pd_flags_t;

endpackage : serv_predecode_fifo_pkg
`default_nettype wire

// File: rtl/serv_predecode_flags.sv
`default_nettype none
// ============================================================================
//  Module      : serv_predecode_flags
//  Description : Purely combinational predecoder. Maps a 30-bit fetched
//                word (instruction bits [31:2]) to the five control flags.
//  Ports       : i_word   - instruction bits [31:2]
//                o_flags  - {ebreak, jal_or_jalr, mret, wfi, mdu}
//  Parameters  : MDU      - 1 enables M-extension detection, 0 forces mdu=0
//  Revision    : 1.0 - initial release
// ============================================================================
module serv_predecode_flags
    import serv_predecode_fifo_pkg::*;
#(
    parameter int MDU = 0
) (
    input  logic [WORD_W-1:0] i_word,
    output pd_flags_t         o_flags
);

    // The word is missing instruction bits [1:0], so every field index is
    // the architectural bit position minus two.
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [11:0] imm;
    logic [6:0]  f7;
    logic        sys_plain;

    always_comb begin
        op  = i_word[4:0];     // [6:2]
        rd  = i_word[9:5];     // [11:7]
        f3  = i_word[12:10];   // [14:12]
        rs1 = i_word[17:13];   // [19:15]
        imm = i_word[29:18];   // [31:20]
        f7  = i_word[29:23];   // [31:25]

        // ebreak/mret/wfi share the same frame: SYSTEM, f3=0, rs1=rd=0;
        // only the immediate tells them apart.
        sys_plain = (op == OP_SYSTEM) && (f3 == 3'b000) &&
                    (rs1 == 5'd0) && (rd == 5'd0);

        o_flags             = '0;
        o_flags.ebreak      = sys_plain && (imm == IMM_EBREAK);
        o_flags.mret        = sys_plain && (imm == IMM_MRET);
        o_flags.wfi         = sys_plain && (imm == IMM_WFI);
        o_flags.jal_or_jalr = (op == OP_JAL) || (op == OP_JALR);
        o_flags.mdu         = (MDU != 0) && (op == OP_OP) && (f7 == F7_MULDIV);
    end

endmodule : serv_predecode_flags
`default_nettype wire

// File: rtl/serv_predecode_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : serv_predecode_fifo
//  Description : Instruction queue between the ibus and serv_decode.
//                Buffers DEPTH fetched words and presents the head entry
//                together with predecoded control flags through a
//                valid/consume handshake.
//  Ports       : clk            - clock, rising edge
//                i_rst          - asynchronous active-high reset
//                i_wb_rdt       - fetched instruction bits [31:2]
//                i_wb_en        - write strobe, one word per cycle
//                i_flush        - discard all entries
//                i_rd_en        - consume head entry
//                o_full/o_valid - occupancy == DEPTH / != 0
//                o_count        - occupancy
//                o_ovf          - sticky: write attempted while full
//                o_rdt          - head word, 0 when empty
//                o_ebreak, o_jal_or_jalr, o_mret, o_wfi, o_mdu_op
//                               - head flags, 0 when empty
//  Parameters  : DEPTH          - entries, power of two, >= 2
//                PRE_REGISTER   - 1: flags decoded at write and stored
//                                 0: flags decoded from the head word
//                MDU            - enable o_mdu_op decode
//  Revision    : 1.0 - initial release
// ============================================================================
module serv_predecode_fifo
    import serv_predecode_fifo_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int PRE_REGISTER = 1,
    parameter int MDU          = 0
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic [WORD_W-1:0]          i_wb_rdt,
    input  logic                       i_wb_en,
    input  logic                       i_flush,
    input  logic                       i_rd_en,
    output logic                       o_full,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_ovf,
    output logic [WORD_W-1:0]          o_rdt,
    output logic                       o_ebreak,
    output logic                       o_jal_or_jalr,
    output logic                       o_mret,
    output logic                       o_wfi,
    output logic                       o_mdu_op
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              ovf_q,    ovf_d;

    logic              full;
    logic              valid;
    logic              wr_acc;
    logic              rd_acc;

    // Storage (not reset: contents are only observable through count)
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] head_word;
    pd_flags_t         head_flags;

    assign full   = (count_q == CW'(DEPTH));
    assign valid  = (count_q != '0);

    // A write while full is dropped even when a read frees a slot in the
    // same cycle: there is no pass-through path.
    assign wr_acc = i_wb_en && !full;
    assign rd_acc = i_rd_en && valid;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (i_flush) begin
            // Flush dominates any same-cycle read or write.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);   // wraps mod DEPTH
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (i_wb_en && full) begin
                ovf_d = 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !i_flush) begin
            mem_q[wr_ptr_q] <= i_wb_rdt;
        end
    end

    assign head_word = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Flag predecode: either stored per entry or derived from the head
    // ------------------------------------------------------------------
    generate
        if (PRE_REGISTER != 0) begin : g_pre_reg
            pd_flags_t wr_flags;
            pd_flags_t flags_q [DEPTH];

            serv_predecode_flags #(
                .MDU     (MDU)
            ) u_flags (
                .i_word  (i_wb_rdt),
                .o_flags (wr_flags)
            );

            always_ff @(posedge clk) begin
                if (wr_acc && !i_flush) begin
                    flags_q[wr_ptr_q] <= wr_flags;
                end
            end

            assign head_flags = flags_q[rd_ptr_q];
        end else begin : g_head_dec
            serv_predecode_flags #(
                .MDU     (MDU)
            ) u_flags (
                .i_word  (head_word),
                .o_flags (head_flags)
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs: everything about the head is masked by valid so stale
    // storage never leaks out of an empty queue.
    // ------------------------------------------------------------------
    assign o_full        = full;
    assign o_valid       = valid;
    assign o_count       = count_q;
    assign o_ovf         = ovf_q;
    assign o_rdt         = valid ? head_word : '0;
    assign o_ebreak      = valid && head_flags.ebreak;
    assign o_jal_or_jalr = valid && head_flags.jal_or_jalr;
    assign o_mret        = valid && head_flags.mret;
    assign o_wfi         = valid && head_flags.wfi;
    assign o_mdu_op      = valid && head_flags.mdu;

endmodule : serv_predecode_fifo
`default_nettype wire

// File: tb/tb_serv_predecode_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serv_predecode_fifo
//  Description : Directed self-checking bench. Five instances share the
//                stimulus; only the selected one sees enables, and its
//                outputs are muxed onto the observation signals.
//                  dut0 D=2 P=0 M=1   dut1 D=2 P=1 M=1
//                  dut2 D=4 P=0 M=1   dut3 D=4 P=1 M=1   dut4 D=4 P=1 M=0
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serv_predecode_fifo;

    localparam int NDUT = 5;

    localparam logic [29:0] W_EBREAK = 30'h0004001C;
    localparam logic [29:0] W_MRET   = 30'h0C08001C;
    localparam logic [29:0] W_WFI    = 30'h0414001C;
    localparam logic [29:0] W_JAL    = 30'h0000001B;
    localparam logic [29:0] W_MUL    = 30'h008C402C;

    // flag vector order: {ebreak, jal_or_jalr, mret, wfi, mdu}
    localparam logic [4:0]  F_EBREAK = 5'b10000;
    localparam logic [4:0]  F_JAL    = 5'b01000;
    localparam logic [4:0]  F_MRET   = 5'b00100;
    localparam logic [4:0]  F_WFI    = 5'b00010;
    localparam logic [4:0]  F_MDU    = 5'b00001;

    function automatic int dep_of(input int k);
        return (k < 2) ? 2 : 4;
    endfunction
    function automatic int pre_of(input int k);
        return (k == 4) ? 1 : (k % 2);
    endfunction
    function automatic int mdu_of(input int k);
        return (k == 4) ? 0 : 1;
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [29:0] wb_rdt = '0;
    logic        wb_en = 1'b0;
    logic        flush = 1'b0;
    logic        rd_en = 1'b0;
    int          sel = 0;

    logic        full_a  [NDUT];
    logic        valid_a [NDUT];
    logic [2:0]  cnt_a   [NDUT];
    logic        ovf_a   [NDUT];
    logic [29:0] rdt_a   [NDUT];
    logic        eb_a    [NDUT];
    logic        jl_a    [NDUT];
    logic        mr_a    [NDUT];
    logic        wf_a    [NDUT];
    logic        md_a    [NDUT];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            localparam int D = dep_of(g);
            logic [$clog2(D):0] cnt;

            serv_predecode_fifo #(
                .DEPTH        (D),
                .PRE_REGISTER (pre_of(g)),
                .MDU          (mdu_of(g))
            ) u_dut (
                .clk           (clk),
                .i_rst         (rst),
                .i_wb_rdt      (wb_rdt),
                .i_wb_en       (wb_en && (sel == g)),
                .i_flush       (flush && (sel == g)),
                .i_rd_en       (rd_en && (sel == g)),
                .o_full        (full_a[g]),
                .o_valid       (valid_a[g]),
                .o_count       (cnt),
                .o_ovf         (ovf_a[g]),
                .o_rdt         (rdt_a[g]),
                .o_ebreak      (eb_a[g]),
                .o_jal_or_jalr (jl_a[g]),
                .o_mret        (mr_a[g]),
                .o_wfi         (wf_a[g]),
                .o_mdu_op      (md_a[g])
            );

            assign cnt_a[g] = 3'(cnt);
        end
    endgenerate

    function automatic logic [4:0] cur_flags();
        return {eb_a[sel], jl_a[sel], mr_a[sel], wf_a[sel], md_a[sel]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s dut%0d: got %h want %h", tag, sel, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [29:0] w);
        wb_rdt = w;
        wb_en  = 1'b1;
        tick();
        wb_en  = 1'b0;
    endtask

    task automatic rd();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".count"}, 32'(cnt_a[sel]), 32'd0);
        chk({tag, ".valid"}, 32'(valid_a[sel]), 32'd0);
        chk({tag, ".rdt"},   32'(rdt_a[sel]), 32'd0);
        chk({tag, ".flags"}, 32'(cur_flags()), 32'd0);
    endtask

    logic [29:0] t1_w [4];
    logic [4:0]  t1_f [4];

    initial begin
        t1_w = '{W_EBREAK, W_MRET, W_WFI, W_JAL};
        t1_f = '{F_EBREAK, F_MRET, F_WFI, F_JAL};

        for (int k = 0; k < NDUT; k++) begin
            int d;
            int m;
            sel = k;
            d   = dep_of(k);
            m   = mdu_of(k);

            // ---- reset state
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk_empty("rst");
            chk("rst.full", 32'(full_a[sel]), 32'd0);
            chk("rst.ovf",  32'(ovf_a[sel]), 32'd0);

            // ---- 1: each flag alone on its own entry, in chunks of DEPTH
            for (int base = 0; base < 4; base += d) begin
                for (int i = 0; i < d; i++) begin
                    wr(t1_w[base+i]);
                    chk("t1.wcount", 32'(cnt_a[sel]), 32'(i + 1));
                end
                chk("t1.full", 32'(full_a[sel]), 32'd1);
                for (int i = 0; i < d; i++) begin
                    chk("t1.rdt",    32'(rdt_a[sel]), 32'(t1_w[base+i]));
                    chk("t1.flags",  32'(cur_flags()), 32'(t1_f[base+i]));
                    chk("t1.rcount", 32'(cnt_a[sel]), 32'(d - i));
                    rd();
                end
                chk_empty("t1.end");
            end

            // ---- 2: M-extension decode, then a read while empty
            wr(W_MUL);
            chk("t2.valid", 32'(valid_a[sel]), 32'd1);
            chk("t2.flags", 32'(cur_flags()), (m != 0) ? 32'(F_MDU) : 32'd0);
            rd();
            rd();
            chk_empty("t2.rd_empty");

            // ---- 3: overflow, third write dropped, ovf sticky until flush
            for (int i = 0; i <= d; i++) begin
                wr(30'h100 + 30'(i));
                chk("t3.count", 32'(cnt_a[sel]), 32'((i + 1 < d) ? i + 1 : d));
                chk("t3.full",  32'(full_a[sel]), 32'((i + 1 >= d) ? 1 : 0));
            end
            chk("t3.ovf", 32'(ovf_a[sel]), 32'd1);
            for (int i = 0; i < d; i++) begin
                chk("t3.rdt", 32'(rdt_a[sel]), 32'h100 + 32'(i));
                rd();
            end
            chk("t3.empty", 32'(cnt_a[sel]), 32'd0);
            chk("t3.ovf_sticky", 32'(ovf_a[sel]), 32'd1);
            flush = 1'b1;
            tick();
            flush = 1'b0;
            chk("t3.ovf_clr", 32'(ovf_a[sel]), 32'd0);

            // ---- 4: simultaneous read/write across pointer wrap
            wr(30'h200);
            chk("t4.head0", 32'(rdt_a[sel]), 32'h200);
            for (int i = 0; i < 10; i++) begin
                wb_rdt = 30'h201 + 30'(i);
                wb_en  = 1'b1;
                rd_en  = 1'b1;
                tick();
                chk("t4.count", 32'(cnt_a[sel]), 32'd1);
                chk("t4.rdt",   32'(rdt_a[sel]), 32'h201 + 32'(i));
            end
            wb_en = 1'b0;
            rd_en = 1'b0;
            rd();
            chk_empty("t4.end");

            // ---- 5: flush beats a same-cycle write at count=2
            wr(W_EBREAK);
            wr(W_EBREAK);
            chk("t5.count2", 32'(cnt_a[sel]), 32'd2);
            if (d == 2) begin
                wr(W_EBREAK);
                chk("t5.ovf_set", 32'(ovf_a[sel]), 32'd1);
            end
            wb_rdt = W_JAL;
            wb_en  = 1'b1;
            flush  = 1'b1;
            tick();
            wb_en  = 1'b0;
            flush  = 1'b0;
            chk_empty("t5.flush");
            chk("t5.ovf", 32'(ovf_a[sel]), 32'd0);
            tick();
            chk("t5.lost", 32'(cnt_a[sel]), 32'd0);

            // ---- 6: asynchronous reset between edges
            wr(W_MRET);
            wr(W_JAL);
            @(negedge clk);
            #2;
            rst = 1'b1;
            #1;
            chk_empty("t6.async");
            chk("t6.full", 32'(full_a[sel]), 32'd0);
            tick();
            rst = 1'b0;
            wr(W_WFI);
            chk("t6.count", 32'(cnt_a[sel]), 32'd1);
            chk("t6.rdt",   32'(rdt_a[sel]), 32'(W_WFI));
            chk("t6.flags", 32'(cur_flags()), 32'(F_WFI));
            rd();
            chk_empty("t6.end");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_serv_predecode_fifo
`default_nettype wire
